instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage feeding `instruction_fifo`. It holds the fetch PC and issues one request at a time to the instruction cache over a req/addr_ok/data_ok handshake. Each response yields one or two instruction words, which are written into the FIFO together with their addresses. Branch and exception redirects arriving from the pipeline are applied, and any in-flight response made stale by a redirect is discarded.

## Interface
Parameters:
- `RESET_PC`, default 32'hbfc0_0000: fetch PC after reset.

Ports (reset is asynchronous, active-high, single clock domain):
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `redirect_valid` in 1: pipeline redirect request; takes priority over sequential fetch.
- `redirect_pc` in 32: redirect target.
- `fifo_full` in 1: the FIFO's `full` output.
- `inst_req` out 1: cache request valid.
- `inst_addr` out 32: request address; bits [1:0] always 0.
- `inst_addr_ok` in 1: cache accepted the request this cycle.
- `inst_data_ok` in 1: response data valid this cycle.
- `inst_rdata1` in 32: word at the request address.
- `inst_rdata2` in 32: word at request address + 4.
- `fifo_write_en1`, `fifo_write_en2` out 1 each: FIFO write enables.
- `fifo_write_data1`, `fifo_write_data2` out 32 each: words written to the FIFO.
- `fifo_write_address1`, `fifo_write_address2` out 32 each: PCs of those words.

## Operation
- State register `state` with four states:
  - IDLE: no request outstanding.
  - REQ: request presented to the cache, not yet accepted.
  - WAIT: request accepted, awaiting data.
  - DROP: accepted request made stale by a redirect; its response is discarded.
- `pc`: 32-bit register. It is loaded with `redirect_pc & ~3` in any state whenever `redirect_valid` is 1.
- IDLE:
  - `fifo_full`=0 → REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `inst_req`=1 and `inst_addr`=`pc`.
  - `inst_addr_ok`=1 → WAIT, or DROP if `redirect_valid` is 1 in the same cycle.
  - A redirect without `inst_addr_ok` stays in REQ; the address changes, which the cache permits before acceptance.
- WAIT:
  - `inst_data_ok`=1 with no redirect: write to the FIFO, advance `pc` by the words written, → IDLE.
  - `inst_data_ok`=1 with `redirect_valid`=1: no write, `pc` = redirect target, → IDLE.
  - `redirect_valid`=1 without data: → DROP.
- DROP:
  - `inst_data_ok`=1 → IDLE with no write.
  - Further redirects only update `pc`.
- Write word count (dual mode):
  - `pc[2]`=0: two words. en1=en2=1; data1/2 = rdata1/2; addresses `pc` and `pc`+4; `pc` += 8.
  - `pc[2]`=1: one word, because the second word lies past the 8-byte block. en1=1, en2=0; `pc` += 4.
- PC arithmetic is modulo 2^32; 32'hffff_fffc + 4 wraps to 0.
- `fifo_write_en2` is never 1 without `fifo_write_en1`.
- One outstanding request at most, and `fifo_full` is checked only in IDLE. FIFO `full` leaves at least 2 free slots, so no overflow can occur.

## Timing
- Reset values:
  - `state`=IDLE, `pc`=`RESET_PC`.
  - `inst_req`=0, `inst_addr`=`RESET_PC`.
  - All `fifo_write_*` outputs = 0.
- Minimum fetch loop is 3 cycles: IDLE → REQ with `addr_ok` → WAIT with `data_ok` → IDLE.
- FIFO write outputs are combinational from `inst_data_ok` in WAIT, so the write occurs in the same cycle as `data_ok`.
- `inst_addr` and `inst_req` are registered-state derived and carry no combinational path from `inst_*_ok`.
- `rst` asserted mid-transaction returns the block to IDLE immediately. The cache must drop its own outstanding response on the same reset.
- The FIFO clears on redirect through its own reset. The fetch stage never writes in a redirect cycle.

## Configuration
- `INSTRUCTION_FETCH_DUAL_EN` defined: dual-word fetch as described above.
- `INSTRUCTION_FETCH_DUAL_EN` undefined:
  - Every response writes one word: `fifo_write_en2` tied 0, `fifo_write_data2` and `fifo_write_address2` tied 0.
  - `pc` always advances by 4.
  - `inst_rdata2` is ignored.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_state_t` enum (IDLE, REQ, WAIT, DROP).
  - `FETCH_RESET_PC` constant, used as the default of `RESET_PC`.
  - `FETCH_BLOCK_BYTES` constant = 8.
- One natural sub-module, `fetch_pc_gen`. It is combinational and computes the next `pc` and the write-word count from `pc`, the redirect inputs and the handshake. The top level holds the FSM and registers.

## Test plan
- Reset release with cache responding `addr_ok` and `data_ok` one cycle each: first request at `inst_addr`=32'hbfc00000. FIFO receives 32'hbfc00000 and 32'hbfc00004; next request at 32'hbfc00008.
- Redirect to 32'h80000014: single write at 32'h80000014 (en2=0); next request at 32'h80000018, which then returns two words.
- Redirect during WAIT to 32'h80001000: response at the next `data_ok` is dropped (no en1). Next request is at 32'h80001000.
- Redirect in the same cycle as `data_ok`: no FIFO write; next state IDLE; next request uses the redirect target.
- `fifo_full`=1 held 5 cycles: `inst_req` stays 0 throughout; request issues one cycle after full deasserts.
- Without `INSTRUCTION_FETCH_DUAL_EN`: from `RESET_PC`, three responses write single words at +0, +4 and +8; en2 remains 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM state enum and fetch block geometry.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_t;

  localparam logic [31:0] FETCH_RESET_PC    = 32'hbfc0_0000;
  localparam logic [31:0] FETCH_BLOCK_BYTES = 32'd8;
  localparam logic [31:0] FETCH_WORD_BYTES  = 32'd4;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC and write-word-count logic for instruction_fetch (combinational).
// Ports: i_pc, i_redirect_valid, i_redirect_pc, i_write -> o_next_pc, o_two_words.
// Dual-word fetch enabled by INSTRUCTION_FETCH_DUAL_EN.
module fetch_pc_gen
  import fetch_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_write,
  output logic [31:0] o_next_pc,
  output logic        o_two_words
);

`ifdef INSTRUCTION_FETCH_DUAL_EN
  // Second word is only in the same 8-byte block when pc sits on its first word.
  assign o_two_words = ~i_pc[2];
`else
  assign o_two_words = 1'b0;
`endif

  logic [31:0] w_step;
  assign w_step = o_two_words ? FETCH_BLOCK_BYTES : FETCH_WORD_BYTES;

  // i_write is never set in a redirect cycle, so the arms are exclusive.
  always_comb begin
    o_next_pc = i_pc;
    unique case (1'b1)
      i_redirect_valid: o_next_pc = i_redirect_pc & ~32'd3;
      i_write:          o_next_pc = i_pc + w_step;
      default:          o_next_pc = i_pc;
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding icache request, writes 1-2 words per response
// into the instruction FIFO, applies redirects and drops stale responses.
// Ports: clk, rst, redirect_valid/pc, fifo_full, inst_req/addr/addr_ok/
// data_ok/rdata1/rdata2, fifo_write_en/data/address 1 and 2.
// Dual-word fetch enabled by INSTRUCTION_FETCH_DUAL_EN.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fifo_full,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata1,
  input  logic [31:0] inst_rdata2,
  output logic        fifo_write_en1,
  output logic        fifo_write_en2,
  output logic [31:0] fifo_write_data1,
  output logic [31:0] fifo_write_data2,
  output logic [31:0] fifo_write_address1,
  output logic [31:0] fifo_write_address2
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  w_next_pc;
  logic         w_two_words;
  logic         w_write;

  assign w_write = (r_state == WAIT) & inst_data_ok & ~redirect_valid;

  fetch_pc_gen u_pc_gen (
    .i_pc             (r_pc),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_write          (w_write),
    .o_next_pc        (w_next_pc),
    .o_two_words      (w_two_words)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
      unique case (r_state)
        IDLE: if (!fifo_full) r_state <= REQ;
        REQ:  if (inst_addr_ok)
                r_state <= redirect_valid ? DROP : WAIT;
        WAIT: if (inst_data_ok)        r_state <= IDLE;
              else if (redirect_valid) r_state <= DROP;
        DROP: if (inst_data_ok) r_state <= IDLE;
      endcase
    end
  end

  assign inst_req  = (r_state == REQ);
  assign inst_addr = {r_pc[31:2], 2'b00};

  assign fifo_write_en1      = w_write;
  assign fifo_write_en2      = w_write & w_two_words;
  assign fifo_write_data1    = w_write ? inst_rdata1 : 32'd0;
  assign fifo_write_address1 = w_write ? inst_addr : 32'd0;

`ifdef INSTRUCTION_FETCH_DUAL_EN
  assign fifo_write_data2    = fifo_write_en2 ? inst_rdata2 : 32'd0;
  assign fifo_write_address2 = fifo_write_en2 ? inst_addr + FETCH_WORD_BYTES
                                              : 32'd0;
`else
  logic w_unused_rdata2;
  assign w_unused_rdata2     = ^inst_rdata2;
  assign fifo_write_data2    = 32'd0;
  assign fifo_write_address2 = 32'd0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a cache model drives handshakes,
// expectations are queued and a negedge monitor checks requests and writes.
module tb_instruction_fetch;

`ifdef INSTRUCTION_FETCH_DUAL_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif
  localparam logic [31:0] K = 32'h5a5a_a5a5;
  localparam logic [31:0] RST_PC = 32'hbfc0_0000;

  logic        clk = 0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fifo_full;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata1;
  logic [31:0] inst_rdata2;
  logic        fifo_write_en1;
  logic        fifo_write_en2;
  logic [31:0] fifo_write_data1;
  logic [31:0] fifo_write_data2;
  logic [31:0] fifo_write_address1;
  logic [31:0] fifo_write_address2;

  instruction_fetch dut (
    .clk                 (clk),
    .rst                 (rst),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .fifo_full           (fifo_full),
    .inst_req            (inst_req),
    .inst_addr           (inst_addr),
    .inst_addr_ok        (inst_addr_ok),
    .inst_data_ok        (inst_data_ok),
    .inst_rdata1         (inst_rdata1),
    .inst_rdata2         (inst_rdata2),
    .fifo_write_en1      (fifo_write_en1),
    .fifo_write_en2      (fifo_write_en2),
    .fifo_write_data1    (fifo_write_data1),
    .fifo_write_data2    (fifo_write_data2),
    .fifo_write_address1 (fifo_write_address1),
    .fifo_write_address2 (fifo_write_address2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        two;
    logic [31:0] a1, d1, a2, d2;
  } wr_t;

  logic [31:0] req_q[$];
  wr_t         wr_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (inst_req && inst_addr_ok) begin
        if (req_q.size() == 0) begin
          total++; bad++;
          $display("FAIL req_extra: addr %h, none expected", inst_addr);
        end else begin
          chk("req_addr", inst_addr, req_q.pop_front());
        end
      end
      if (fifo_write_en1) begin
        if (wr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_extra: addr %h, no write expected",
                   fifo_write_address1);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("wr_en2", {31'd0, fifo_write_en2}, {31'd0, w.two});
          chk("wr_addr1", fifo_write_address1, w.a1);
          chk("wr_data1", fifo_write_data1, w.d1);
          if (w.two || !DUAL) begin
            chk("wr_addr2", fifo_write_address2, w.a2);
            chk("wr_data2", fifo_write_data2, w.d2);
          end
        end
      end
      if (fifo_write_en2 && !fifo_write_en1) begin
        total++; bad++;
        $display("FAIL en2_alone: en2=1 en1=0, want en2=0");
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!inst_req && n < 20) begin
      step();
      n++;
    end
    if (!inst_req) begin
      total++; bad++;
      $display("FAIL req_timeout: inst_req=0 after %0d cycles, want 1", n);
    end
  endtask

  task automatic accept(input logic [31:0] exp, output logic [31:0] a);
    wait_req();
    req_q.push_back(exp);
    a = inst_addr;
    inst_addr_ok = 1;
    step();
    inst_addr_ok = 0;
  endtask

  task automatic respond(input logic [31:0] a, input bit wr, input bit two,
                         input logic [31:0] exp);
    wr_t w;
    if (wr) begin
      w.two = two;
      w.a1  = exp;
      w.d1  = exp ^ K;
      w.a2  = two ? exp + 32'd4 : 32'd0;
      w.d2  = two ? (exp + 32'd4) ^ K : 32'd0;
      wr_q.push_back(w);
    end
    inst_data_ok = 1;
    inst_rdata1  = a ^ K;
    inst_rdata2  = (a + 32'd4) ^ K;
    step();
    inst_data_ok = 0;
  endtask

  task automatic fetch(input logic [31:0] exp, input bit two);
    logic [31:0] a;
    accept(exp, a);
    respond(a, 1'b1, two, exp);
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1;
    redirect_pc    = pc;
    step();
    redirect_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    rst = 1; redirect_valid = 0; redirect_pc = 0; fifo_full = 0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata1 = 0; inst_rdata2 = 0;
    @(negedge clk);
    chk("rst_req", {31'd0, inst_req}, 32'd0);
    chk("rst_addr", inst_addr, RST_PC);
    chk("rst_en", {30'd0, fifo_write_en1, fifo_write_en2}, 32'd0);
    chk("rst_wdata", fifo_write_data1 | fifo_write_data2, 32'd0);
    chk("rst_waddr", fifo_write_address1 | fifo_write_address2, 32'd0);
    step();
    rst = 0;

    fetch(32'hbfc0_0000, DUAL);
    fetch(DUAL ? 32'hbfc0_0008 : 32'hbfc0_0004, DUAL);

    redirect(32'h8000_0014);
    fetch(32'h8000_0014, 1'b0);
    fetch(32'h8000_0018, DUAL);

    accept(DUAL ? 32'h8000_0020 : 32'h8000_001c, a);
    redirect_valid = 1; redirect_pc = 32'h8000_1000;
    step();
    redirect_valid = 0;
    step();
    respond(a, 1'b0, 1'b0, 32'd0);
    fetch(32'h8000_1000, DUAL);

    accept(DUAL ? 32'h8000_1008 : 32'h8000_1004, a);
    redirect_valid = 1; redirect_pc = 32'h8000_2007;
    respond(a, 1'b0, 1'b0, 32'd0);
    redirect_valid = 0;
    chk("idle_after_redir", {31'd0, inst_req}, 32'd0);
    fetch(32'h8000_2004, 1'b0);

    fifo_full = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("full_noreq", {31'd0, inst_req}, 32'd0);
    end
    fifo_full = 0;
    step();
    chk("req_after_full", {31'd0, inst_req}, 32'd1);
    fetch(32'h8000_2008, DUAL);

    redirect(32'hffff_fffc);
    fetch(32'hffff_fffc, 1'b0);
    fetch(32'h0000_0000, DUAL);

    wait_req();
    chk("req_pre_redir", inst_addr, DUAL ? 32'h8 : 32'h4);
    redirect(32'h8000_3000);
    chk("req_hold", {31'd0, inst_req}, 32'd1);
    chk("req_newaddr", inst_addr, 32'h8000_3000);
    fetch(32'h8000_3000, DUAL);

    wait_req();
    req_q.push_back(DUAL ? 32'h8000_3008 : 32'h8000_3004);
    a = inst_addr;
    inst_addr_ok = 1; redirect_valid = 1; redirect_pc = 32'h8000_4000;
    step();
    inst_addr_ok = 0; redirect_valid = 0;
    respond(a, 1'b0, 1'b0, 32'd0);
    fetch(32'h8000_4000, DUAL);

    accept(DUAL ? 32'h8000_4008 : 32'h8000_4004, a);
    rst = 1;
    #1;
    chk("midrst_req", {31'd0, inst_req}, 32'd0);
    chk("midrst_addr", inst_addr, RST_PC);
    chk("midrst_en", {31'd0, fifo_write_en1}, 32'd0);
    step();
    rst = 0;
    fetch(32'hbfc0_0000, DUAL);

    step();
    chk("req_q_empty", req_q.size(), 32'd0);
    chk("wr_q_empty", wr_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
